// File: rtl/axi4_lite_fetch_master.sv
// Read-only AXI4-Lite master turning core fetch requests into single
// AXI read transactions; one transaction in flight, flush-aware.
//
// Ports:
//   iCLK, iRST          clock (rising edge), synchronous active-high reset
//   iFETCH_REQ/ADDR     fetch request and byte address from the core
//   oFETCH_READY        high in IDLE, a request can be accepted
//   oFETCH_VALID/DATA   fetched word presented (HOLD) until ACK or flush
//   oFETCH_ERR          bus error (RRESP != OKAY) or misaligned address
//   iFETCH_ACK          core consumes the presented word
//   iFLUSH              redirect: abandon the current request
//   m_AR*, m_R*         AXI4-Lite read address / read data channels
//   m_AW*, m_W*, m_B*   write channels, permanently idle
module axi4_lite_fetch_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iFETCH_REQ,
    input  logic [ADDR_WIDTH-1:0]     iFETCH_ADDR,
    output logic                      oFETCH_READY,
    output logic                      oFETCH_VALID,
    output logic [DATA_WIDTH-1:0]     oFETCH_DATA,
    output logic                      oFETCH_ERR,
    input  logic                      iFETCH_ACK,
    input  logic                      iFLUSH,
    output logic                      m_ARVALID,
    input  logic                      m_ARREADY,
    output logic [ADDR_WIDTH-1:0]     m_ARADDR,
    output logic [2:0]                m_ARPROT,
    input  logic                      m_RVALID,
    output logic                      m_RREADY,
    input  logic [1:0]                m_RRESP,
    input  logic [DATA_WIDTH-1:0]     m_RDATA,
    output logic                      m_AWVALID,
    output logic [ADDR_WIDTH-1:0]     m_AWADDR,
    output logic [2:0]                m_AWPROT,
    output logic                      m_WVALID,
    output logic [DATA_WIDTH-1:0]     m_WDATA,
    output logic [DATA_WIDTH/8-1:0]   m_WSTRB,
    output logic                      m_BREADY
);

    // Byte-offset bits that must be zero for a word-aligned fetch.
    localparam int LSB = $clog2(DATA_WIDTH / 8);

    // Instruction, secure, unprivileged.
    localparam logic [2:0] PROT_INSN = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic                    discard_q, discard_d;
    logic                    misaligned;

    assign misaligned = (iFETCH_ADDR[LSB-1:0] != '0);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            err_q     <= err_d;
            discard_q <= discard_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        err_d     = err_q;
        discard_d = discard_q;
        unique case (state_q)
            S_IDLE: begin
                if (iFETCH_REQ && !iFLUSH) begin
                    addr_d = iFETCH_ADDR;
                    data_d = '0;
                    // Misaligned fetches fault locally, never reach the bus.
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                // ARVALID must stay up until accepted, so a flush only
                // marks the response for dropping.
                if (iFLUSH) begin
                    discard_d = 1'b1;
                end
                if (m_ARREADY) begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (iFLUSH) begin
                    discard_d = 1'b1;
                end
                if (m_RVALID) begin
                    // A flush arriving with the response also drops it.
                    if (discard_q || iFLUSH) begin
                        state_d   = S_IDLE;
                        discard_d = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        data_d  = m_RDATA;
                        err_d   = (m_RRESP != 2'b00);
                    end
                end
            end
            S_HOLD: begin
                if (iFLUSH || iFETCH_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign oFETCH_READY = (state_q == S_IDLE);
    assign oFETCH_VALID = (state_q == S_HOLD);
    assign oFETCH_DATA  = data_q;
    assign oFETCH_ERR   = err_q;

    assign m_ARVALID = (state_q == S_ADDR);
    assign m_ARADDR  = addr_q;
    assign m_ARPROT  = (state_q == S_ADDR) ? PROT_INSN : 3'b000;
    assign m_RREADY  = (state_q == S_DATA);

    assign m_AWVALID = 1'b0;
    assign m_AWADDR  = '0;
    assign m_AWPROT  = 3'b000;
    assign m_WVALID  = 1'b0;
    assign m_WDATA   = '0;
    assign m_WSTRB   = '0;
    assign m_BREADY  = 1'b0;

endmodule

// File: tb/tb_axi4_lite_fetch_master.sv
// Bench for axi4_lite_fetch_master: behavioural ROM slave, directed
// fetches, scoreboard queue checked by a monitor on each VALID word.
module tb_axi4_lite_fetch_master;

    logic        iCLK;
    logic        iRST;
    logic        iFETCH_REQ;
    logic [31:0] iFETCH_ADDR;
    logic        oFETCH_READY;
    logic        oFETCH_VALID;
    logic [31:0] oFETCH_DATA;
    logic        oFETCH_ERR;
    logic        iFETCH_ACK;
    logic        iFLUSH;
    logic        m_ARVALID;
    logic        m_ARREADY;
    logic [31:0] m_ARADDR;
    logic [2:0]  m_ARPROT;
    logic        m_RVALID;
    logic        m_RREADY;
    logic [1:0]  m_RRESP;
    logic [31:0] m_RDATA;
    logic        m_AWVALID;
    logic [31:0] m_AWADDR;
    logic [2:0]  m_AWPROT;
    logic        m_WVALID;
    logic [31:0] m_WDATA;
    logic [3:0]  m_WSTRB;
    logic        m_BREADY;

    axi4_lite_fetch_master #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32)
    ) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iFETCH_REQ(iFETCH_REQ),
        .iFETCH_ADDR(iFETCH_ADDR),
        .oFETCH_READY(oFETCH_READY),
        .oFETCH_VALID(oFETCH_VALID),
        .oFETCH_DATA(oFETCH_DATA),
        .oFETCH_ERR(oFETCH_ERR),
        .iFETCH_ACK(iFETCH_ACK),
        .iFLUSH(iFLUSH),
        .m_ARVALID(m_ARVALID),
        .m_ARREADY(m_ARREADY),
        .m_ARADDR(m_ARADDR),
        .m_ARPROT(m_ARPROT),
        .m_RVALID(m_RVALID),
        .m_RREADY(m_RREADY),
        .m_RRESP(m_RRESP),
        .m_RDATA(m_RDATA),
        .m_AWVALID(m_AWVALID),
        .m_AWADDR(m_AWADDR),
        .m_AWPROT(m_AWPROT),
        .m_WVALID(m_WVALID),
        .m_WDATA(m_WDATA),
        .m_WSTRB(m_WSTRB),
        .m_BREADY(m_BREADY)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    int total = 0;
    int bad   = 0;

    // Expected {data, err} per presented word.
    logic [32:0] expq[$];

    // Slave configuration.
    int          s_ard   = 0;
    int          s_rd    = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_rresp = '0;
    int          r_count = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Behavioural ROM slave: ARREADY after s_ard cycles of ARVALID,
    // RVALID s_rd cycles after the AR handshake.
    initial begin : slave
        int   cnt;
        int   ph;
        logic ar_hs;
        logic r_hs;
        m_ARREADY = 1'b0;
        m_RVALID  = 1'b0;
        m_RDATA   = '0;
        m_RRESP   = '0;
        cnt = 0;
        ph  = 0;
        forever begin
            @(posedge iCLK);
            ar_hs = m_ARVALID & m_ARREADY;
            r_hs  = m_RVALID & m_RREADY;
            #1;
            if (iRST) begin
                m_ARREADY = 1'b0;
                m_RVALID  = 1'b0;
                cnt = 0;
                ph  = 0;
            end else begin
                if (ph == 2) begin
                    if (r_hs) begin
                        m_RVALID = 1'b0;
                        r_count++;
                        ph = 0;
                    end
                end else if (ph == 0) begin
                    if (ar_hs) begin
                        m_ARREADY = 1'b0;
                        cnt = 0;
                        ph  = 1;
                    end else if (m_ARVALID) begin
                        if (cnt >= s_ard) m_ARREADY = 1'b1;
                        else cnt++;
                    end
                end
                if (ph == 1) begin
                    if (cnt >= s_rd) begin
                        m_RVALID = 1'b1;
                        m_RDATA  = s_rdata;
                        m_RRESP  = s_rresp;
                        ph = 2;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: compare each newly presented word against the queue.
    initial begin : monitor
        logic        seen;
        logic [32:0] e;
        seen = 1'b0;
        forever begin
            @(negedge iCLK);
            if (oFETCH_VALID && !seen) begin
                seen = 1'b1;
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got data %h want none",
                             oFETCH_DATA);
                end else begin
                    e = expq.pop_front();
                    chk("mon_data", oFETCH_DATA, e[32:1]);
                    chk("mon_err", {31'd0, oFETCH_ERR}, {31'd0, e[0]});
                end
            end else if (!oFETCH_VALID) begin
                seen = 1'b0;
            end
        end
    end

    // Issue one fetch starting just after a rising edge with READY high.
    task automatic do_fetch(input logic [31:0] a, input logic [31:0] rd,
                            input logic [1:0] rr, input int ard,
                            input int ackd, input bit use_flush,
                            output int lat, output int arc,
                            output int arb);
        s_ard   = ard;
        s_rd    = 0;
        s_rdata = rd;
        s_rresp = rr;
        if (a[1:0] != 2'b00) expq.push_back({32'd0, 1'b1});
        else expq.push_back({rd, (rr != 2'b00)});
        iFETCH_ADDR = a;
        iFETCH_REQ  = 1'b1;
        lat = 0;
        arc = 0;
        arb = 0;
        do begin
            @(posedge iCLK);
            #1;
            iFETCH_REQ = 1'b0;
            lat++;
            if (m_ARVALID) begin
                arc++;
                if (m_ARADDR !== a || m_ARPROT !== 3'b100) arb++;
            end
        end while (!oFETCH_VALID && lat < 50);
        if (lat >= 50) chk("valid_timeout", 32'd0, 32'd1);
        for (int i = 0; i < ackd; i++) begin
            @(posedge iCLK);
            #1;
        end
        chk("valid_held", {31'd0, oFETCH_VALID}, 32'd1);
        if (use_flush) iFLUSH = 1'b1;
        else iFETCH_ACK = 1'b1;
        @(posedge iCLK);
        #1;
        iFLUSH     = 1'b0;
        iFETCH_ACK = 1'b0;
        chk("ready_after_hold", {31'd0, oFETCH_READY}, 32'd1);
        chk("valid_after_hold", {31'd0, oFETCH_VALID}, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got hang want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat;
        int arc;
        int arb;
        int rc;
        int n;
        iRST        = 1'b1;
        iFETCH_REQ  = 1'b0;
        iFETCH_ADDR = '0;
        iFETCH_ACK  = 1'b0;
        iFLUSH      = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;

        chk("rst_ready", {31'd0, oFETCH_READY}, 32'd1);
        chk("rst_valid", {31'd0, oFETCH_VALID}, 32'd0);
        chk("rst_err", {31'd0, oFETCH_ERR}, 32'd0);
        chk("rst_data", oFETCH_DATA, 32'd0);
        chk("rst_arvalid", {31'd0, m_ARVALID}, 32'd0);
        chk("rst_araddr", m_ARADDR, 32'd0);
        chk("rst_arprot", {29'd0, m_ARPROT}, 32'd0);
        chk("rst_rready", {31'd0, m_RREADY}, 32'd0);
        chk("rst_wr_idle", {29'd0, m_AWVALID, m_WVALID, m_BREADY}, 32'd0);

        // 1: minimum latency fetch of 0x0.
        do_fetch(32'h0, 32'h0000_0013, 2'b00, 0, 0, 1'b0, lat, arc, arb);
        chk("t1_latency", lat, 3);
        chk("t1_ar_cycles", arc, 1);
        chk("t1_ar_addr_prot", arb, 0);

        // 2: ARREADY delayed 3 cycles, ACK 5 cycles late.
        do_fetch(32'h104, 32'h1234_5678, 2'b00, 3, 5, 1'b0, lat, arc, arb);
        chk("t2_ar_cycles", arc, 4);
        chk("t2_ar_stable", arb, 0);
        chk("t2_latency", lat, 6);

        // 3: slave error response.
        do_fetch(32'h8, 32'hCAFE_F00D, 2'b10, 0, 1, 1'b0, lat, arc, arb);
        chk("t3_latency", lat, 3);

        // 4: misaligned fetch never reaches the bus.
        do_fetch(32'h6, 32'hFFFF_FFFF, 2'b00, 0, 0, 1'b0, lat, arc, arb);
        chk("t4_latency", lat, 1);
        chk("t4_no_arvalid", arc, 0);

        // 5: flush during DATA drops the response.
        s_ard   = 0;
        s_rd    = 2;
        s_rdata = 32'hDEAD_BEEF;
        s_rresp = 2'b00;
        rc = r_count;
        iFETCH_ADDR = 32'h10;
        iFETCH_REQ  = 1'b1;
        @(posedge iCLK);
        #1;
        iFETCH_REQ = 1'b0;
        @(posedge iCLK);
        #1;
        chk("t5_in_data", {31'd0, m_RREADY}, 32'd1);
        iFLUSH = 1'b1;
        @(posedge iCLK);
        #1;
        iFLUSH = 1'b0;
        chk("t5_busy_after_flush", {31'd0, oFETCH_READY}, 32'd0);
        n = 0;
        while (!oFETCH_READY && n < 20) begin
            @(posedge iCLK);
            #1;
            n++;
        end
        chk("t5_ready_back", {31'd0, oFETCH_READY}, 32'd1);
        @(posedge iCLK);
        #1;
        chk("t5_r_handshake", r_count, rc + 1);
        chk("t5_no_valid", {31'd0, oFETCH_VALID}, 32'd0);
        do_fetch(32'h20, 32'h0000_0033, 2'b00, 0, 0, 1'b0, lat, arc, arb);
        chk("t5_next_latency", lat, 3);

        // Flush while holding a word: dropped, back to IDLE.
        do_fetch(32'h24, 32'h0000_0044, 2'b00, 0, 1, 1'b1, lat, arc, arb);

        // Flush in IDLE suppresses a simultaneous request.
        iFETCH_ADDR = 32'h28;
        iFETCH_REQ  = 1'b1;
        iFLUSH      = 1'b1;
        @(posedge iCLK);
        #1;
        iFETCH_REQ = 1'b0;
        iFLUSH     = 1'b0;
        chk("idle_flush_ready", {31'd0, oFETCH_READY}, 32'd1);
        chk("idle_flush_noar", {31'd0, m_ARVALID}, 32'd0);

        // 6: reset while in ADDR.
        s_ard = 5;
        s_rd  = 0;
        iFETCH_ADDR = 32'h40;
        iFETCH_REQ  = 1'b1;
        @(posedge iCLK);
        #1;
        iFETCH_REQ = 1'b0;
        chk("t6_in_addr", {31'd0, m_ARVALID}, 32'd1);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        chk("t6_arvalid", {31'd0, m_ARVALID}, 32'd0);
        chk("t6_ready", {31'd0, oFETCH_READY}, 32'd1);
        chk("t6_valid", {31'd0, oFETCH_VALID}, 32'd0);

        // Normal operation after reset.
        do_fetch(32'h44, 32'h0000_0055, 2'b00, 0, 0, 1'b0, lat, arc, arb);
        chk("post_rst_latency", lat, 3);

        repeat (3) @(posedge iCLK);
        #1;
        chk("queue_empty", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
